fmac_result_buffer: RTL

//  Output stage directly downstream of the FMA normalise/round stage.

---
 rtl/fmac_result_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fmac_result_buffer.sv
// fmac_result_buffer: output stage that follows the FMA normalise/round stage.
//   Packs {sign, exponent, mantissa} into an IEEE-754 word. An invalid
//   operation produces the canonical quiet NaN instead.
//   Builds a per-result {NV,DZ,OF,UF,NX} vector and keeps a sticky OR of the
//   flags of every retired result.
//   A 2-entry valid/ready skid buffer (main + skid) separates the round stage
//   from the writeback consumer. In_ready_o comes straight from a register.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   In_valid_i / In_ready_o         upstream handshake
//   Sign/Exp/Mant_result_i          result fields (hidden bit removed)
//   Invalid/Overflow/Underflow/Inexact_i  exception flags of the result
//   Flush_i                         drop every buffered result
//   Fflags_clr_i                    clear the accumulated flags
//   Out_valid_o / Out_ready_i       downstream handshake
//   Result_o, Fflags_o              head result and its flags (0 when idle)
//   Fflags_acc_o                    sticky flags of retired results
module fmac_result_buffer #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_XLEN = 1 + PARM_EXP + PARM_MANT,
  parameter logic [PARM_MANT-1:0] PARM_MANT_NAN = {1'b1, {(PARM_MANT-1){1'b0}}}
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 In_valid_i,
  output logic                 In_ready_o,
  input  logic                 Sign_result_i,
  input  logic [PARM_EXP-1:0]  Exp_result_i,
  input  logic [PARM_MANT-1:0] Mant_result_i,
  input  logic                 Invalid_i,
  input  logic                 Overflow_i,
  input  logic                 Underflow_i,
  input  logic                 Inexact_i,
  input  logic                 Flush_i,
  input  logic                 Fflags_clr_i,
  output logic                 Out_valid_o,
  input  logic                 Out_ready_i,
  output logic [PARM_XLEN-1:0] Result_o,
  output logic [4:0]           Fflags_o,
  output logic [4:0]           Fflags_acc_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q;
  logic [PARM_XLEN-1:0] main_word_q, skid_word_q;
  logic [4:0]           main_flags_q, skid_flags_q;
  logic [4:0]           acc_q;
  logic                 out_valid_q, in_ready_q;

  logic [PARM_XLEN-1:0] pack_word;
  logic [4:0]           pack_flags;
  logic                 accept, retire;

  always_comb begin
    pack_word = {Sign_result_i, Exp_result_i, Mant_result_i};
    if (Invalid_i) begin
      pack_word = {1'b0, {PARM_EXP{1'b1}}, PARM_MANT_NAN};
    end
    // DZ cannot arise from an FMA.
    pack_flags = {Invalid_i, 1'b0, Overflow_i, Underflow_i, Inexact_i};
  end

  assign accept = In_valid_i & in_ready_q;
  assign retire = out_valid_q & Out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StEmpty;
      main_word_q  <= '0;
      main_flags_q <= '0;
      skid_word_q  <= '0;
      skid_flags_q <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // The accumulator only sees retired results. A flush does not stop this.
      acc_q <= (Fflags_clr_i ? 5'b0 : acc_q) | (retire ? main_flags_q : 5'b0);

      if (Flush_i) begin
        state_q      <= StEmpty;
        main_word_q  <= '0;
        main_flags_q <= '0;
        skid_word_q  <= '0;
        skid_flags_q <= '0;
        out_valid_q  <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              state_q      <= StOne;
              main_word_q  <= pack_word;
              main_flags_q <= pack_flags;
              out_valid_q  <= 1'b1;
            end
          end
          StOne: begin
            if (accept && retire) begin
              main_word_q  <= pack_word;
              main_flags_q <= pack_flags;
            end else if (accept) begin
              state_q      <= StFull;
              skid_word_q  <= pack_word;
              skid_flags_q <= pack_flags;
              in_ready_q   <= 1'b0;
            end else if (retire) begin
              state_q      <= StEmpty;
              main_word_q  <= '0;
              main_flags_q <= '0;
              out_valid_q  <= 1'b0;
            end
          end
          StFull: begin
            if (retire) begin
              state_q      <= StOne;
              main_word_q  <= skid_word_q;
              main_flags_q <= skid_flags_q;
              skid_word_q  <= '0;
              skid_flags_q <= '0;
              in_ready_q   <= 1'b1;
            end
          end
          default: begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign In_ready_o   = in_ready_q;
  assign Out_valid_o  = out_valid_q;
  assign Result_o     = main_word_q;
  assign Fflags_o     = main_flags_q;
  assign Fflags_acc_o = acc_q;

endmodule
